// File: rtl/counter_game.sv
// counter_game: up/down game counter with entry pulses, win/loss tallies and sticky game-over
module counter_game #(
  parameter int WIDTH      = 8,
  parameter int STEP_LO    = 1,
  parameter int STEP_HI    = 2,
  parameter int SATURATE   = 0,
  parameter int RESET_VAL  = 1,
  parameter int GAME_LIMIT = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                en,
  input  logic                                init,
  input  logic [1:0]                          ctrl,
  input  logic [WIDTH-1:0]                    load,
  output logic [WIDTH-1:0]                    count,
  output logic                                winner,
  output logic                                loser,
  output logic [$clog2(GAME_LIMIT+1)-1:0]     win_tally,
  output logic [$clog2(GAME_LIMIT+1)-1:0]     lose_tally,
  output logic                                gameover,
  output logic                                game_winner
);
  localparam int TW = $clog2(GAME_LIMIT+1);
  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH:0] LO = (WIDTH+1)'(STEP_LO);
  localparam logic [WIDTH:0] HI = (WIDTH+1)'(STEP_HI);
  logic [WIDTH-1:0] r_count;
  logic             r_winner, r_loser, r_gameover, r_game_winner;
  logic [TW-1:0]    r_win_tally, r_lose_tally;
  logic [WIDTH:0]   w_step, w_up, w_dn;
  logic [WIDTH-1:0] w_stepped, w_next;
  logic             w_win, w_lose, w_end;
  logic [TW-1:0]    w_win_inc, w_lose_inc;
  // next count and entry detection; the extra top bit of w_up/w_dn flags overflow/borrow for clamping
  always_comb begin
    w_step     = ctrl[0] ? HI : LO;
    w_up       = {1'b0, r_count} + w_step;
    w_dn       = {1'b0, r_count} - w_step;
    w_stepped  = ctrl[1] ? ((SATURATE != 0 && w_dn[WIDTH]) ? '0 : w_dn[WIDTH-1:0])
                         : ((SATURATE != 0 && w_up[WIDTH]) ? MAX : w_up[WIDTH-1:0]);
    w_next     = init ? load : en ? w_stepped : r_count;
    w_win      = !r_gameover && w_next == MAX && r_count != MAX;
    w_lose     = !r_gameover && w_next == '0 && r_count != '0;
    w_win_inc  = r_win_tally + TW'(1);
    w_lose_inc = r_lose_tally + TW'(1);
    w_end      = (w_win && w_win_inc == TW'(GAME_LIMIT)) || (w_lose && w_lose_inc == TW'(GAME_LIMIT));
  end
  // game state register; everything freezes once the game is over except the pulses, which drop
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count       <= WIDTH'(RESET_VAL);
      r_winner      <= 1'b0;
      r_loser       <= 1'b0;
      r_win_tally   <= '0;
      r_lose_tally  <= '0;
      r_gameover    <= 1'b0;
      r_game_winner <= 1'b0;
    end else if (!r_gameover) begin
      r_count  <= w_next;
      r_winner <= w_win;
      r_loser  <= w_lose;
      if (w_win) r_win_tally <= w_win_inc;
      if (w_lose) r_lose_tally <= w_lose_inc;
      if (w_end) begin
        r_gameover    <= 1'b1;
        r_game_winner <= w_win;
      end
    end else begin
      r_winner <= 1'b0;
      r_loser  <= 1'b0;
    end
  end
  assign count       = r_count;
  assign winner      = r_winner;
  assign loser       = r_loser;
  assign win_tally   = r_win_tally;
  assign lose_tally  = r_lose_tally;
  assign gameover    = r_gameover;
  assign game_winner = r_game_winner;
endmodule

// File: doc/counter_game.md
Name: counter_game

Overview:
- Parametrised up/down game counter with four step modes, synchronous load, and wrap or saturate arithmetic.
- Emits a one-cycle winner pulse when count enters all-ones and a loser pulse when count enters zero.
- Tallies wins and losses. Declares game over when either tally reaches a limit, then freezes.
- Sits beside the existing 8-bit counter as its generalised successor for the scoreboard datapath.

Parameters:
WIDTH, 8, counter width in bits (>=2)
STEP_LO, 1, small step magnitude (1 <= STEP_LO < 2**WIDTH)
STEP_HI, 2, large step magnitude (1 <= STEP_HI < 2**WIDTH)
SATURATE, 0, 0 = modulo 2**WIDTH wrap; 1 = clamp at 0 and MAX
RESET_VAL, 1, count value after reset
GAME_LIMIT, 3, number of wins or losses that ends the game (>=1)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  count enable for ctrl stepping
init  input  1  synchronous load strobe
ctrl  input  2  00 +STEP_LO, 01 +STEP_HI, 10 -STEP_LO, 11 -STEP_HI
load  input  WIDTH  value loaded on init
count  output  WIDTH  registered counter value
winner  output  1  one-cycle pulse: count entered MAX
loser  output  1  one-cycle pulse: count entered 0
win_tally  output  TW  wins so far; TW = $clog2(GAME_LIMIT+1)
lose_tally  output  TW  losses so far
gameover  output  1  sticky: game finished
game_winner  output  1  valid when gameover: 1 = win limit hit, 0 = loss limit hit

Behaviour:
- MAX = 2**WIDTH-1. All outputs are registered.
- Reset (reset=0, async): count=RESET_VAL, winner=loser=0, tallies=0, gameover=0, game_winner=0. Deassertion is sampled at the next clk edge. Reset mid-game discards all state.
- Next-count priority when not gameover:
  - init=1: next = load. Ignores en and ctrl.
  - else en=1: next = count ± step per ctrl.
  - else: hold.
- Arithmetic:
  - SATURATE=0: result taken modulo 2**WIDTH; a step may skip past MAX or 0 without hitting it.
  - SATURATE=1: an up step exceeding MAX gives MAX; a down step below 0 gives 0. Compute in WIDTH+1 bits.
- Entry events:
  - winner is registered on the same edge as count: winner <= (next==MAX) && (count!=MAX).
  - loser <= (next==0) && (count!=0).
  - The pulse is therefore high in the same cycle count first shows the value.
  - Holding at MAX or 0, including repeated saturated steps, gives no further pulses.
  - Entry via init counts as an entry.
  - winner and loser are never both high.
- Tallies:
  - On a winner entry, win_tally += 1; on a loser entry, lose_tally += 1, on the same edge as the pulse.
  - If the incremented tally equals GAME_LIMIT: gameover<=1 and game_winner<=(winner side), on that same edge.
- Game over (gameover=1):
  - count, tallies and game_winner freeze.
  - init, en and ctrl are ignored; winner and loser stay 0 after the final pulse cycle.
  - Only reset clears it.
- RESET_VAL==0 or MAX produces no pulse at reset; the first pulse requires leaving and re-entering the value.

Test Plan:
- Reset with defaults, en=1, ctrl=00 for 254 cycles -> count runs 1..255. winner=1 only in the cycle count=255; win_tally=1.
- SATURATE=0, load 0xFE via init, then ctrl=01 -> count=0x00, loser pulse, no winner. Next ctrl=00 -> count=0x01, no pulse.
- SATURATE=1, count=0xFE, ctrl=01 twice -> count 0xFF with one winner pulse, then holds 0xFF with no second pulse. Count=0x01, ctrl=11 -> 0x00 with a loser pulse.
- GAME_LIMIT=3: drive three loser entries via init load=0 alternating with load=5 -> on the third, gameover=1, game_winner=0, lose_tally=3. Subsequent init/en/ctrl leave count unchanged.
- init=1 with en=1, ctrl=00, load=0x40 -> count=0x40 (load wins). en=0, ctrl=01 for 5 cycles -> count holds 0x40.
- Assert reset low asynchronously mid-cycle while gameover=1 -> outputs return to reset values immediately without a clock edge. Counting resumes from 1 after release.
